// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-master AXI read arbiter and its
// address decoder.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Slave-select encodings driven on sel_s
  localparam logic [1:0] SEL_S0  = 2'd0;
  localparam logic [1:0] SEL_S1  = 2'd1;
  localparam logic [1:0] SEL_DEF = 2'd2;

  // 64 KiB regions: the address bits above REGION_LSB pick the slave
  localparam int          REGION_LSB = 16;
  localparam logic [15:0] REGION_S0  = 16'h0000;
  localparam logic [15:0] REGION_S1  = 16'h0001;

endpackage

// File: rtl/axi_addr_dec.sv
// Combinational region decoder: maps an AXI address onto S0, S1 or the
// default slave. Shared by the read and write paths.
module axi_addr_dec
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [1:0]        sel
);

  logic [ADDR_W-1:0] region;

  assign region = addr >> REGION_LSB;

  always_comb begin
    if (region == ADDR_W'(REGION_S0))
      sel = SEL_S0;
    else if (region == ADDR_W'(REGION_S1))
      sel = SEL_S1;
    else
      sel = SEL_DEF;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master, single-outstanding AXI read arbiter with round-robin grant,
// address-region slave select and burst-length checking.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        arvalid_m,
  input  logic [ADDR_W-1:0] araddr_m0,
  input  logic [ADDR_W-1:0] araddr_m1,
  input  logic [LEN_W-1:0]  arlen_m0,
  input  logic [LEN_W-1:0]  arlen_m1,
  input  logic              arready_s,
  input  logic              rvalid_s,
  input  logic              rready_m,
  input  logic              rlast_s,
  output logic [1:0]        grant,
  output logic [1:0]        sel_s,
  output logic              ar_en,
  output logic              r_en,
  output logic              busy,
  output logic              len_err
);

  state_t            state, state_next;
  logic              last_gnt;   // index of the master served most recently
  logic              win;
  logic [ADDR_W-1:0] win_addr;
  logic [1:0]        win_sel;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    beat_cnt;
  logic              ar_hs, r_hs, last_beat;

  // On a tie the master that was not served last wins
  assign win      = (arvalid_m == 2'b11) ? ~last_gnt : arvalid_m[1];
  assign win_addr = win ? araddr_m1 : araddr_m0;

  axi_addr_dec #(.ADDR_W(ADDR_W)) u_dec (
    .addr (win_addr),
    .sel  (win_sel)
  );

  assign ar_hs     = (state == ST_ADDR) && |(arvalid_m & grant) && arready_s;
  assign r_hs      = (state == ST_DATA) && rvalid_s && rready_m;
  assign last_beat = (beat_cnt == {1'b0, len_q});

  assign ar_en = (state == ST_ADDR);
  assign r_en  = (state == ST_DATA);
  assign busy  = (state != ST_IDLE);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next is defaulted first so no path through the case can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (|arvalid_m)       state_next = ST_ADDR;
      ST_ADDR: if (ar_hs)            state_next = ST_DATA;
      ST_DATA: if (r_hs && rlast_s)  state_next = ST_IDLE;
      default:                       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant    <= 2'b00;
      sel_s    <= SEL_S0;
      len_q    <= '0;
      beat_cnt <= '0;
      last_gnt <= 1'b1;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        ST_IDLE: if (|arvalid_m) begin
          grant <= win ? 2'b10 : 2'b01;
          sel_s <= win_sel;
          len_q <= win ? arlen_m1 : arlen_m0;
        end
        ST_ADDR: if (ar_hs) beat_cnt <= '0;
        ST_DATA: if (r_hs) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (rlast_s) begin
            len_err  <= ~last_beat;
            last_gnt <= grant[1];
            grant    <= 2'b00;
            sel_s    <= SEL_S0;
          end else if (last_beat) begin
            // Expected-last beat without RLAST: flag it, keep draining
            len_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: transaction-level reference model
// (round-robin winner, region decode, beat-count vs ARLEN) driving directed
// and randomized read transactions.
module tb_axi_rd_arbiter;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        arvalid_m;
  logic [ADDR_W-1:0] araddr_m0, araddr_m1;
  logic [LEN_W-1:0]  arlen_m0, arlen_m1;
  logic              arready_s, rvalid_s, rready_m, rlast_s;
  logic [1:0]        grant, sel_s;
  logic              ar_en, r_en, busy, len_err;

  int compared   = 0;
  int mismatched = 0;

  bit         model_last;   // 1 when M1 was served most recently
  int         busy_cycles;
  logic [1:0] obs_grant;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .arvalid_m (arvalid_m),
    .araddr_m0 (araddr_m0),
    .araddr_m1 (araddr_m1),
    .arlen_m0  (arlen_m0),
    .arlen_m1  (arlen_m1),
    .arready_s (arready_s),
    .rvalid_s  (rvalid_s),
    .rready_m  (rready_m),
    .rlast_s   (rlast_s),
    .grant     (grant),
    .sel_s     (sel_s),
    .ar_en     (ar_en),
    .r_en      (r_en),
    .busy      (busy),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ref_sel(input logic [31:0] a);
    if (a[31:16] == 16'h0000) return 2'd0;
    if (a[31:16] == 16'h0001) return 2'd1;
    return 2'd2;
  endfunction

  // Observed outputs packed as {grant, sel_s, ar_en, r_en, busy, len_err}
  function automatic logic [7:0] outs();
    return {grant, sel_s, ar_en, r_en, busy, len_err};
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    case ($urandom_range(0, 2))
      0:       a[31:16] = 16'h0000;
      1:       a[31:16] = 16'h0001;
      default: a[31:16] = 16'($urandom_range(2, 16'hffff));
    endcase
    return a;
  endfunction

  task automatic idle_inputs();
    arvalid_m = 2'b00; araddr_m0 = '0; araddr_m1 = '0;
    arlen_m0 = '0; arlen_m1 = '0;
    arready_s = 1'b0; rvalid_s = 1'b0; rready_m = 1'b0; rlast_s = 1'b0;
  endtask

  // One complete read transaction from IDLE back to IDLE, checked every cycle
  task automatic run_txn(input string tag, input logic [1:0] req,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [3:0] l0, input logic [3:0] l1,
                         input int ar_wait, input int rlast_at,
                         input bit gaps, input bit drop, input bit keep);
    bit         w, err;
    logic [1:0] eg, es;
    int         el;
    logic [7:0] exp, got;
    w  = (req == 2'b11) ? !model_last : req[1];
    eg = w ? 2'b10 : 2'b01;
    es = ref_sel(w ? a1 : a0);
    el = int'(w ? l1 : l0);
    busy_cycles = 0;

    araddr_m0 = a0; araddr_m1 = a1; arlen_m0 = l0; arlen_m1 = l1;
    arvalid_m = req;
    step();
    obs_grant = grant;

    for (int k = 0; k <= ar_wait; k++) begin
      exp = {eg, es, 4'b1010};
      got = outs();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL %s addr[%0d]: got %b want %b", tag, k, got, exp);
      end
      busy_cycles += int'(busy);
      if (k == ar_wait) begin
        arready_s    = 1'b1;
        arvalid_m[w] = 1'b1;
      end else if (drop) begin
        arvalid_m[w] = 1'b0;
        arready_s    = 1'($urandom_range(0, 1));
      end else begin
        arready_s = 1'b0;
      end
      step();
    end
    arready_s = 1'b0;
    if (!keep) arvalid_m = 2'b00;

    err = 1'b0;
    for (int b = 0; b <= rlast_at; b++) begin
      for (int g = (gaps ? $urandom_range(0, 2) : 0); g > 0; g--) begin
        exp = {eg, es, 3'b011, err};
        got = outs();
        compared++;
        if (got !== exp) begin
          mismatched++;
          $display("FAIL %s stall[%0d]: got %b want %b", tag, b, got, exp);
        end
        busy_cycles += int'(busy);
        rvalid_s = 1'($urandom_range(0, 1));
        rready_m = ~rvalid_s;
        rlast_s  = 1'($urandom_range(0, 1));
        step();
        err = 1'b0;
      end
      exp = {eg, es, 3'b011, err};
      got = outs();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL %s beat[%0d]: got %b want %b", tag, b, got, exp);
      end
      busy_cycles += int'(busy);
      rvalid_s = 1'b1; rready_m = 1'b1; rlast_s = (b == rlast_at);
      step();
      err = (b == rlast_at) ? (b != el) : (b == el);
    end
    rvalid_s = 1'b0; rready_m = 1'b0; rlast_s = 1'b0;

    exp = {7'b0, err};
    got = outs();
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s exit: got %b want %b", tag, got, exp);
    end
    model_last = w;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    compared++;
    if (outs() !== 8'b0) begin
      mismatched++;
      $display("FAIL reset_async: got %b want %b", outs(), 8'b0);
    end
    step(); step();
    rst = 1'b0;
    model_last = 1'b1;
    step();
    compared++;
    if (outs() !== 8'b0) begin
      mismatched++;
      $display("FAIL reset_idle: got %b want %b", outs(), 8'b0);
    end
  endtask

  task automatic test_single_m0();
    run_txn("single_m0", 2'b01, 32'h0000_0040, 32'h0, 4'd3, 4'd0, 1, 3, 0, 0, 0);
    compared++;
    if (busy_cycles != 6) begin
      mismatched++;
      $display("FAIL single_m0 busy_len: got %0d want %0d", busy_cycles, 6);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] expect_seq [4];
    expect_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b1;
    arvalid_m = 2'b11;
    step();
    rst = 1'b0;
    model_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_txn("round_robin", 2'b11, 32'h0000_1000, 32'h0001_2000,
              4'd0, 4'd0, 0, 0, 0, 0, 1);
      compared++;
      if (obs_grant !== expect_seq[i]) begin
        mismatched++;
        $display("FAIL rr_order[%0d]: got %b want %b", i, obs_grant, expect_seq[i]);
      end
    end
    arvalid_m = 2'b00;
  endtask

  task automatic test_decode();
    run_txn("decode_s1",  2'b10, 32'h0, 32'h0001_0000, 4'd0, 4'd1, 0, 1, 0, 0, 0);
    run_txn("decode_def", 2'b10, 32'h0, 32'h0005_0000, 4'd0, 4'd0, 2, 0, 0, 0, 0);
  endtask

  task automatic test_len_err();
    run_txn("early_rlast", 2'b01, 32'h0000_0100, 32'h0, 4'd1, 4'd0, 0, 0, 0, 0, 0);
    run_txn("late_rlast",  2'b01, 32'h0000_0200, 32'h0, 4'd0, 4'd0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    arvalid_m = 2'b01; araddr_m0 = 32'h0000_0080; arlen_m0 = 4'd3;
    step();
    arready_s = 1'b1;
    step();
    arready_s = 1'b0; arvalid_m = 2'b00;
    rvalid_s = 1'b1; rready_m = 1'b1;
    step();
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (outs() !== 8'b0) begin
      mismatched++;
      $display("FAIL reset_mid_async: got %b want %b", outs(), 8'b0);
    end
    idle_inputs();
    step();
    rst = 1'b0;
    model_last = 1'b1;
    run_txn("after_reset_m1", 2'b10, 32'h0, 32'h0001_0040, 4'd0, 4'd2, 0, 2, 0, 0, 0);
  endtask

  task automatic test_drop_valid();
    run_txn("drop_valid", 2'b01, 32'h0000_0400, 32'h0, 4'd1, 4'd0, 3, 1, 0, 1, 0);
  endtask

  task automatic test_random();
    logic [1:0] req;
    logic [3:0] l0, l1;
    int         len_w, rl;
    for (int i = 0; i < 40; i++) begin
      req   = 2'($urandom_range(1, 3));
      l0    = 4'($urandom_range(0, 3));
      l1    = 4'($urandom_range(0, 3));
      len_w = (req == 2'b11) ? int'(model_last ? l0 : l1) : int'(req[1] ? l1 : l0);
      rl    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len_w + 1) : len_w;
      run_txn("random", req, rand_addr(), rand_addr(), l0, l1,
              $urandom_range(0, 3), rl, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      arvalid_m = 2'b00;
    end
  endtask

  initial begin
    test_reset();
    test_single_m0();
    test_round_robin();
    test_decode();
    test_len_err();
    test_reset_mid();
    test_drop_valid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
